// File: rtl/mem_bus_master.sv
// Command FIFO in front of a native valid/ready memory bus; one transfer outstanding at a time.
// Optional wait-state timeout abort is compiled in with `define MEM_MASTER_TIMEOUT_EN.
module mem_bus_master #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_instr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_write,
    output logic        rsp_error
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic        write;
        logic        instr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t        state_q, state_d;
    cmd_t          fifo_q [FIFO_DEPTH];
    cmd_t          fifo_d [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_en_q, ready_en_d;
    logic          push, pop;

    logic          req_write_q, req_write_d;
    logic          req_instr_q, req_instr_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   req_wdata_q, req_wdata_d;
    logic [3:0]    req_wstrb_q, req_wstrb_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_write_q, rsp_write_d;
`ifdef MEM_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_error_q, rsp_error_d;
`endif

    // cmd_ready stays low through reset and rises on the first edge after release
    assign cmd_ready  = ready_en_q & (count_q != (AW+1)'(FIFO_DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state_q == S_IDLE) & (count_q != '0);
    assign head       = fifo_q[rd_ptr_q];
    assign ready_en_d = 1'b1;

    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{write: cmd_write, instr: cmd_instr, addr: cmd_addr[31:2],
                                 wdata: cmd_wdata, wstrb: (cmd_write ? cmd_wstrb : 4'b0000)};
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_instr_d = req_instr_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_write_d = rsp_write_q;
`ifdef MEM_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        rsp_error_d = rsp_error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d     = S_REQ;
                    req_write_d = head.write;
                    req_instr_d = head.instr;
                    req_addr_d  = {head.addr, 2'b00};
                    req_wdata_d = head.wdata;
                    req_wstrb_d = head.wstrb;
`ifdef MEM_MASTER_TIMEOUT_EN
                    wait_cnt_d  = '0;
`endif
                end
            end
            S_REQ: begin
                // a ready on the timeout edge still counts as a normal completion
                if (mem_ready) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = req_write_q ? 32'h0 : mem_rdata;
                    rsp_write_d = req_write_q;
`ifdef MEM_MASTER_TIMEOUT_EN
                    rsp_error_d = 1'b0;
`endif
                end
`ifdef MEM_MASTER_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = 32'h0;
                    rsp_write_d = req_write_q;
                    rsp_error_d = 1'b1;
                end else begin
                    wait_cnt_d  = wait_cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_en_q  <= 1'b0;
            req_write_q <= 1'b0;
            req_instr_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_en_q  <= ready_en_d;
            req_write_q <= req_write_d;
            req_instr_q <= req_instr_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_write_q <= rsp_write_d;
`ifdef MEM_MASTER_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            rsp_error_q <= rsp_error_d;
`endif
        end
    end

    assign mem_valid = (state_q == S_REQ);
    assign mem_instr = req_instr_q;
    assign mem_addr  = req_addr_q;
    assign mem_wdata = req_wdata_q;
    assign mem_wstrb = req_wstrb_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_write = rsp_write_q;
`ifdef MEM_MASTER_TIMEOUT_EN
    assign rsp_error = rsp_error_q;
`else
    assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: a wait-state responder plus monitors feed observed queues,
// each scenario task compares them against expectations pushed when its commands are accepted.
module tb_mem_bus_master;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        write;
        logic        error;
    } rsp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_instr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [31:0] rsp_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    req_t exp_req_q[$], obs_req_q[$];
    rsp_t exp_rsp_q[$], obs_rsp_q[$];
    int   req_cyc_q[$], run_q[$];

    bit          hold   = 1'b0;
    int          waits  = 0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    int          wcnt   = 0;
    int          run    = 0;

    always #5 clk = ~clk;

    mem_bus_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_instr(cmd_instr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_write(rsp_write), .rsp_error(rsp_error)
    );

    function automatic logic [31:0] rdfn(input logic [31:0] a);
        return ovr_en ? ovr_data : (a ^ 32'hC3C3_3C3C);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // responder: asserts mem_ready after 'waits' wait cycles unless held off
    always @(posedge clk) begin
        #2;
        if (mem_valid && !hold && wcnt >= waits) begin
            mem_ready = 1'b1;
            mem_rdata = rdfn(mem_addr);
            wcnt      = 0;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            wcnt      = mem_valid ? wcnt + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (mem_valid && mem_ready) begin
                obs_req_q.push_back({mem_addr, mem_wdata, mem_wstrb, mem_instr});
                req_cyc_q.push_back(cyc);
            end
            if (rsp_valid && rsp_ready)
                obs_rsp_q.push_back({rsp_rdata, rsp_write, rsp_error});
            if (mem_valid) run++;
            else if (run > 0) begin
                run_q.push_back(run);
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic send_cmd(input bit w, input bit ins, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input bit tmo, output bit ok);
        req_t er;
        rsp_t ep;
        cmd_valid = 1'b1; cmd_write = w; cmd_instr = ins;
        cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk);
        end
        #1;
        cmd_valid = 1'b0;
        if (ok) begin
            er = {{a[31:2], 2'b00}, wd, (w ? ws : 4'b0000), ins};
            ep = tmo ? {32'h0, w, 1'b1} : {(w ? 32'h0 : rdfn({a[31:2], 2'b00})), w, 1'b0};
            if (!tmo) exp_req_q.push_back(er);
            exp_rsp_q.push_back(ep);
        end
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            if (obs_rsp_q.size() >= n) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        cmd_valid = 0; cmd_write = 0; cmd_instr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; mem_ready = 0; mem_rdata = 0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, mem_valid, rsp_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: got ready/mvalid/rvalid=%b required 000", {cmd_ready, mem_valid, rsp_valid});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_wstrb, mem_instr} !== 69'h0) begin
            n_err++;
            $display("FAIL reset_bus: got addr=%h wdata=%h wstrb=%b required zeros", mem_addr, mem_wdata, mem_wstrb);
        end
        n_cmp++;
        if ({rsp_rdata, rsp_write, rsp_error} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_rsp: got rdata=%h write=%b error=%b required zeros", rsp_rdata, rsp_write, rsp_error);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: got %b required 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_edge: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_read();
        bit ok;
        rsp_t e, o;
        req_t er, orq;
        rsp_ready = 1'b1; waits = 2; ovr_en = 1'b1; ovr_data = 32'h0010_0093;
        send_cmd(1'b0, 1'b1, 32'h0000_0106, 32'h0, 4'b1111, 1'b0, ok);
        n_cmp++;
        if (!ok || mem_valid !== 1'b0) begin
            n_err++;
            $display("FAIL read_accept: got accepted=%b mem_valid=%b required 1/0", ok, mem_valid);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_instr} !== {1'b1, 32'h0000_0104, 4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL read_bus: got valid=%b addr=%h wstrb=%b instr=%b required 1/00000104/0000/1",
                     mem_valid, mem_addr, mem_wstrb, mem_instr);
        end
        wait_rsp(1, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL read_timeout: got no response required 1");
        end
        e = exp_rsp_q.pop_front();
        o = (obs_rsp_q.size() > 0) ? obs_rsp_q.pop_front() : 'x;
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL read_rsp: got rdata=%h write=%b error=%b required rdata=%h write=%b error=%b",
                     o.rdata, o.write, o.error, e.rdata, e.write, e.error);
        end
        er  = exp_req_q.pop_front();
        orq = (obs_req_q.size() > 0) ? obs_req_q.pop_front() : 'x;
        n_cmp++;
        if (orq !== er) begin
            n_err++;
            $display("FAIL read_req: got addr=%h wstrb=%b required addr=%h wstrb=%b", orq.addr, orq.wstrb, er.addr, er.wstrb);
        end
        ovr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        bit ok;
        rsp_t e, o;
        rsp_ready = 1'b1; waits = 3;
        send_cmd(1'b1, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, 4'b0101, 1'b0, ok);
        void'(exp_req_q.pop_front());
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_instr} !== {1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 4'b0101, 1'b0}) begin
                n_err++;
                $display("FAIL write_hold%0d: got valid=%b addr=%h wdata=%h wstrb=%b required 1/00010000/deadbeef/0101",
                         k, mem_valid, mem_addr, mem_wdata, mem_wstrb);
            end
            @(posedge clk);
            #1;
        end
        wait_rsp(1, ok);
        e = exp_rsp_q.pop_front();
        o = (ok && obs_rsp_q.size() > 0) ? obs_rsp_q.pop_front() : 'x;
        void'(obs_req_q.pop_front());
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL write_rsp: got rdata=%h write=%b error=%b required rdata=%h write=%b error=%b",
                     o.rdata, o.write, o.error, e.rdata, e.write, e.error);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_fifo_full();
        bit ok, all_ok;
        rsp_t e, o;
        req_t er, orq;
        bit          w  [5] = '{0, 1, 1, 0, 1};
        bit          ins[5] = '{0, 0, 0, 1, 0};
        logic [31:0] a  [5] = '{32'h200, 32'h204, 32'h20B, 32'h30F, 32'h310};
        logic [31:0] wd [5] = '{32'h0, 32'h1111_2222, 32'h3333_4444, 32'h0, 32'h5555_6666};
        logic [3:0]  ws [5] = '{4'h0, 4'hF, 4'h0, 4'hA, 4'h8};
        rsp_ready = 1'b0; waits = 0; all_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_cmd(w[i], ins[i], a[i], wd[i], ws[i], 1'b0, ok);
            all_ok &= ok;
        end
        n_cmp++;
        if (!all_ok || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: got accepted=%b cmd_ready=%b required 1/0", all_ok, cmd_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, mem_valid, rsp_valid} !== 3'b001) begin
            n_err++;
            $display("FAIL full_stall: got ready/mvalid/rvalid=%b required 001", {cmd_ready, mem_valid, rsp_valid});
        end
        rsp_ready = 1'b1;
        wait_rsp(5, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL full_drain: got %0d responses required 5", obs_rsp_q.size());
        end
        while (exp_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front();
            o = (obs_rsp_q.size() > 0) ? obs_rsp_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL full_rsp: got rdata=%h write=%b error=%b required rdata=%h write=%b error=%b",
                         o.rdata, o.write, o.error, e.rdata, e.write, e.error);
            end
        end
        while (exp_req_q.size() > 0) begin
            er  = exp_req_q.pop_front();
            orq = (obs_req_q.size() > 0) ? obs_req_q.pop_front() : 'x;
            n_cmp++;
            if (orq !== er) begin
                n_err++;
                $display("FAIL full_req: got addr=%h wdata=%h wstrb=%b instr=%b required addr=%h wdata=%h wstrb=%b instr=%b",
                         orq.addr, orq.wdata, orq.wstrb, orq.instr, er.addr, er.wdata, er.wstrb, er.instr);
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        rsp_t e, o;
        rsp_ready = 1'b1; waits = 0;
        req_cyc_q.delete();
        for (int i = 0; i < 4; i++) send_cmd(1'b0, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0, 1'b0, ok);
        wait_rsp(4, ok);
        n_cmp++;
        if (!ok || req_cyc_q.size() < 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d completions required 4", req_cyc_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (req_cyc_q[i] - req_cyc_q[i-1] !== 3) begin
                    n_err++;
                    $display("FAIL b2b_gap%0d: got %0d cycles required 3", i, req_cyc_q[i] - req_cyc_q[i-1]);
                end
            end
        end
        while (exp_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front();
            o = (obs_rsp_q.size() > 0) ? obs_rsp_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL b2b_rsp: got rdata=%h write=%b required rdata=%h write=%b", o.rdata, o.write, e.rdata, e.write);
            end
        end
        exp_req_q.delete();
        obs_req_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

`ifdef MEM_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        rsp_t e, o;
        req_t er, orq;
        rsp_ready = 1'b1; waits = 0; hold = 1'b1;
        run_q.delete();
        send_cmd(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1, ok);
        send_cmd(1'b0, 1'b1, 32'h404, 32'h0, 4'h0, 1'b0, ok);
        for (int i = 0; i < 50 && mem_valid; i++) begin
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
        wait_rsp(2, ok);
        waits = 7;
        send_cmd(1'b0, 1'b0, 32'h408, 32'h0, 4'h0, 1'b0, ok);
        wait_rsp(3, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL tmo_count: got %0d responses required 3", obs_rsp_q.size());
        end
        while (exp_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front();
            o = (obs_rsp_q.size() > 0) ? obs_rsp_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL tmo_rsp: got rdata=%h write=%b error=%b required rdata=%h write=%b error=%b",
                         o.rdata, o.write, o.error, e.rdata, e.write, e.error);
            end
        end
        while (exp_req_q.size() > 0) begin
            er  = exp_req_q.pop_front();
            orq = (obs_req_q.size() > 0) ? obs_req_q.pop_front() : 'x;
            n_cmp++;
            if (orq !== er) begin
                n_err++;
                $display("FAIL tmo_req: got addr=%h required addr=%h", orq.addr, er.addr);
            end
        end
        n_cmp++;
        if (run_q.size() != 3 || run_q[0] != TMO || run_q[1] != 1 || run_q[2] != TMO) begin
            n_err++;
            $display("FAIL tmo_runs: got %0d runs first=%0d required runs 8,1,8", run_q.size(),
                     (run_q.size() > 0) ? run_q[0] : -1);
        end
        waits = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        rsp_t e, o;
        rsp_ready = 1'b1; waits = 0; hold = 1'b1;
        send_cmd(1'b0, 1'b0, 32'h500, 32'h0, 4'h0, 1'b0, ok);
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if ({mem_valid, rsp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL wait_forever: got mvalid/rvalid=%b required 10", {mem_valid, rsp_valid});
        end
        hold = 1'b0;
        wait_rsp(1, ok);
        e = exp_rsp_q.pop_front();
        o = (ok && obs_rsp_q.size() > 0) ? obs_rsp_q.pop_front() : 'x;
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL wait_rsp: got rdata=%h error=%b required rdata=%h error=%b", o.rdata, o.error, e.rdata, e.error);
        end
        exp_req_q.delete();
        obs_req_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_reset_mid();
        bit ok, seen;
        rsp_ready = 1'b1; hold = 1'b1;
        for (int i = 0; i < 3; i++) send_cmd(1'b0, 1'b0, 32'h600 + 32'(i * 4), 32'h0, 4'h0, 1'b0, ok);
        n_cmp++;
        if (mem_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre: got mem_valid=%b required 1", mem_valid);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({mem_valid, cmd_ready, rsp_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_now: got mvalid/ready/rvalid=%b required 000", {mem_valid, cmd_ready, rsp_valid});
        end
        exp_req_q.delete();
        exp_rsp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        hold = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_valid || rsp_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen || obs_rsp_q.size() != 0 || obs_req_q.size() != 0) begin
            n_err++;
            $display("FAIL rst_discard: got activity=%b rsps=%0d reqs=%0d required 0/0/0", seen, obs_rsp_q.size(), obs_req_q.size());
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_ready: got %b required 1", cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_fifo_full();
        test_back_to_back();
`ifdef MEM_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
